// File: rtl/wb_stage.sv
// Write-back stage: a small FIFO that merges load and ALU results and
// retires one entry per cycle to the register file as a one-hot write strobe.
//
// Handshake: a source's result is taken on a rising edge when its
// valid and ready are both high that cycle; ready never depends on valid of
// the same source, only on the registered occupancy, flush_i and (for the ALU
// port) ld_valid_i.
module wb_stage #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid_i,
  input  logic [3:0]  ld_rd_i,
  input  logic [31:0] ld_data_i,
  output logic        ld_ready_o,
  input  logic        alu_valid_i,
  input  logic [3:0]  alu_rd_i,
  input  logic [31:0] alu_data_i,
  output logic        alu_ready_o,
  input  logic        flush_i,
  output logic        wb_o,
  output logic [15:0] wb_r_o,
  output logic [31:0] wb_data_o,
  output logic        stall_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [3:0]    rd_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] free;
  logic [PW-1:0] alu_idx;
  logic          ld_acc, alu_acc, pop;

  logic          wb_q, wb_d;
  logic [15:0]   wb_r_q, wb_r_d;
  logic [31:0]   wb_data_q, wb_data_d;

  // Space is judged on the registered count only, so a pop in the same cycle
  // never makes room for a push; this keeps ready free of the pop path.
  assign free = DEPTH_C - count_q;

  // Ready/accept: load owns the last free slot; everything is refused on flush.
  // While reset is held both readies read 1 but nothing is accepted.
  always_comb begin
    ld_ready_o  = ~rst | ((free >= CW'(1)) & ~flush_i);
    alu_ready_o = ~rst | (~flush_i & ((free >= CW'(2)) |
                                      ((free == CW'(1)) & ~ld_valid_i)));
    ld_acc      = rst & ld_valid_i & ld_ready_o;
    alu_acc     = rst & alu_valid_i & alu_ready_o;
    pop         = (count_q != '0) & ~flush_i;
    // Load is written first so it retires before an ALU result from the same cycle.
    alu_idx     = wr_ptr_q + PW'(ld_acc);
  end

  // Next-state for pointers, occupancy and the registered write-back port.
  always_comb begin
    wr_ptr_d  = wr_ptr_q + PW'(ld_acc) + PW'(alu_acc);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    count_d   = count_q + CW'(ld_acc) + CW'(alu_acc) - CW'(pop);
    wb_d      = 1'b0;
    wb_r_d    = 16'h0000;
    wb_data_d = 32'h0000_0000;
    if (pop) begin
      wb_d      = 1'b1;
      wb_r_d    = 16'h0001 << rd_mem[rd_ptr_q];
      wb_data_d = data_mem[rd_ptr_q];
    end
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Queue storage: contents need no reset, the pointers define what is live.
  always_ff @(posedge clk) begin
    if (ld_acc) begin
      rd_mem[wr_ptr_q]   <= ld_rd_i;
      data_mem[wr_ptr_q] <= ld_data_i;
    end
    if (alu_acc) begin
      rd_mem[alu_idx]    <= alu_rd_i;
      data_mem[alu_idx]  <= alu_data_i;
    end
  end

  // Control state and write-back registers; reset drops every queued entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wb_q      <= 1'b0;
      wb_r_q    <= 16'h0000;
      wb_data_q <= 32'h0000_0000;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wb_q      <= wb_d;
      wb_r_q    <= wb_r_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign wb_o      = wb_q;
  assign wb_r_o    = wb_r_q;
  assign wb_data_o = wb_data_q;
  assign stall_o   = (count_q == DEPTH_C);

endmodule
